// File: rtl/snn_spike_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snn_spike_decoder: windowed per-neuron spike counts, arg-max class result  |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module snn_spike_decoder #(
   parameter int N2     = 2,
   parameter int WINDOW = 64,
   parameter int CNT_W  = 8,
   parameter int IDX_W  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N2-1:0]    spike_in,
   input  logic             start,
   output logic             busy,
   output logic             class_valid,
   input  logic             class_ready,
   output logic [IDX_W-1:0] class_idx,
   output logic [CNT_W-1:0] class_count,
   output logic             no_spike
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COUNT  = 2'd1,
      S_ARGMAX = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] C_WIN_LAST  = CNT_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0] C_SCAN_LAST = IDX_W'(N2 - 1);
   localparam logic [CNT_W-1:0] C_SAT       = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [N2];
   logic [CNT_W-1:0] cnt_d [N2];
   logic [CNT_W-1:0] win_q, win_d;
   logic [IDX_W-1:0] scan_q, scan_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
   logic [IDX_W-1:0] class_idx_q, class_idx_d;
   logic [CNT_W-1:0] class_count_q, class_count_d;
   logic             no_spike_q, no_spike_d;

   logic [CNT_W-1:0] scan_cnt;
   logic             scan_better;
   logic [IDX_W-1:0] next_idx;
   logic [CNT_W-1:0] next_cnt;

   // Strictly-greater compare keeps the lowest index on ties.
   always_comb begin
      scan_cnt    = cnt_q[scan_q];
      scan_better = scan_cnt > best_cnt_q;
      next_idx    = scan_better ? scan_q   : best_idx_q;
      next_cnt    = scan_better ? scan_cnt : best_cnt_q;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      win_d         = win_q;
      scan_d        = scan_q;
      best_idx_d    = best_idx_q;
      best_cnt_d    = best_cnt_q;
      class_idx_d   = class_idx_q;
      class_count_d = class_count_q;
      no_spike_d    = no_spike_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_COUNT;
               for (int i = 0; i < N2; i++) cnt_d[i] = '0;
               win_d      = '0;
               scan_d     = '0;
               best_idx_d = '0;
               best_cnt_d = '0;
            end
         end
         S_COUNT: begin
            for (int i = 0; i < N2; i++) begin
               if (spike_in[i] && (cnt_q[i] != C_SAT)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            win_d = win_q + CNT_W'(1);
            if (win_q == C_WIN_LAST) state_d = S_ARGMAX;
         end
         S_ARGMAX: begin
            best_idx_d = next_idx;
            best_cnt_d = next_cnt;
            scan_d     = scan_q + IDX_W'(1);
            if (scan_q == C_SCAN_LAST) begin
               state_d       = S_HOLD;
               class_idx_d   = next_idx;
               class_count_d = next_cnt;
               no_spike_d    = (next_cnt == '0);
            end
         end
         S_HOLD: begin
            if (class_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '{default: '0};
         win_q         <= '0;
         scan_q        <= '0;
         best_idx_q    <= '0;
         best_cnt_q    <= '0;
         class_idx_q   <= '0;
         class_count_q <= '0;
         no_spike_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         win_q         <= win_d;
         scan_q        <= scan_d;
         best_idx_q    <= best_idx_d;
         best_cnt_q    <= best_cnt_d;
         class_idx_q   <= class_idx_d;
         class_count_q <= class_count_d;
         no_spike_q    <= no_spike_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign class_valid = (state_q == S_HOLD);
   assign class_idx   = class_idx_q;
   assign class_count = class_count_q;
   assign no_spike    = no_spike_q;

endmodule
`default_nettype wire

// File: tb/tb_snn_spike_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_snn_spike_decoder: scoreboard bench, 8-bit and 3-bit counter variants   |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_snn_spike_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] spike_in;
   logic       start;
   logic       class_ready;

   logic       busy, class_valid, no_spike;
   logic [0:0] class_idx;
   logic [7:0] class_count;
   logic       s_busy, s_valid, s_no_spike;
   logic [0:0] s_idx;
   logic [2:0] s_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [0:0] idx;
      logic [7:0] cnt;
      logic       ns;
      logic [0:0] sidx;
      logic [2:0] scnt;
      logic       sns;
   } exp_t;

   exp_t exp_q [$];

   always #5 clk = ~clk;

   snn_spike_decoder #(.N2(2), .WINDOW(8), .CNT_W(8), .IDX_W(1)) u_dut (
      .clk(clk), .reset(reset), .spike_in(spike_in), .start(start),
      .busy(busy), .class_valid(class_valid), .class_ready(class_ready),
      .class_idx(class_idx), .class_count(class_count), .no_spike(no_spike)
   );

   snn_spike_decoder #(.N2(2), .WINDOW(8), .CNT_W(3), .IDX_W(1)) u_sat (
      .clk(clk), .reset(reset), .spike_in(spike_in), .start(start),
      .busy(s_busy), .class_valid(s_valid), .class_ready(class_ready),
      .class_idx(s_idx), .class_count(s_count), .no_spike(s_no_spike)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: count 8 samples with saturation, then strict-greater arg-max.
   function automatic exp_t model(input logic [15:0] pat);
      exp_t e;
      int   c  [2];
      int   sc [2];
      int   bi, bc, sbi, sbc;
      for (int j = 0; j < 2; j++) begin c[j] = 0; sc[j] = 0; end
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 2; j++) begin
            if (pat[2*i+j]) begin
               if (c[j] < 255) c[j]++;
               if (sc[j] < 7) sc[j]++;
            end
         end
      end
      bi = 0; bc = 0; sbi = 0; sbc = 0;
      for (int j = 0; j < 2; j++) begin
         if (c[j] > bc) begin bc = c[j]; bi = j; end
         if (sc[j] > sbc) begin sbc = sc[j]; sbi = j; end
      end
      e.idx  = 1'(bi);
      e.cnt  = 8'(bc);
      e.ns   = (bc == 0);
      e.sidx = 1'(sbi);
      e.scnt = 3'(sbc);
      e.sns  = (sbc == 0);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_decode(input string nm, input logic [15:0] pat, input int wait_n,
                             input bit noise, input bit ready_early);
      exp_t e;
      exp_q.push_back(model(pat));
      start = 1'b1;
      tick();
      start = 1'b0;
      check({nm, "_busy_k"}, 32'(busy), 32'd1);
      class_ready = ready_early;
      for (int i = 0; i < 8; i++) begin
         spike_in = pat[2*i +: 2];
         start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
      end
      start    = 1'b0;
      spike_in = 2'($urandom);
      check({nm, "_valid_k8"}, 32'(class_valid), 32'd0);
      tick();
      check({nm, "_valid_k9"}, 32'(class_valid), 32'd0);
      tick();
      check({nm, "_valid_k10"}, 32'(class_valid), 32'd1);
      check({nm, "_svalid_k10"}, 32'(s_valid), 32'd1);
      if (exp_q.size() == 0) begin
         check({nm, "_sb_empty"}, 32'd1, 32'd0);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      check({nm, "_idx"}, 32'(class_idx), 32'(e.idx));
      check({nm, "_cnt"}, 32'(class_count), 32'(e.cnt));
      check({nm, "_ns"}, 32'(no_spike), 32'(e.ns));
      check({nm, "_sidx"}, 32'(s_idx), 32'(e.sidx));
      check({nm, "_scnt"}, 32'(s_count), 32'(e.scnt));
      check({nm, "_sns"}, 32'(s_no_spike), 32'(e.sns));
      for (int w = 0; w < wait_n; w++) begin
         class_ready = 1'b0;
         tick();
         check({nm, "_hold_valid"}, 32'(class_valid), 32'd1);
         check({nm, "_hold_data"}, {22'd0, class_idx, class_count, no_spike},
               {22'd0, e.idx, e.cnt, e.ns});
      end
      class_ready = 1'b1;
      tick();
      class_ready = 1'b0;
      check({nm, "_acc_valid"}, 32'(class_valid), 32'd0);
      check({nm, "_acc_busy"}, 32'(busy), 32'd0);
      check({nm, "_acc_keep"}, {23'd0, class_idx, class_count}, {23'd0, e.idx, e.cnt});
      tick();
      check({nm, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int seen_valid;
      reset       = 1'b0;
      start       = 1'b0;
      spike_in    = 2'b00;
      class_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         spike_in    = 2'($urandom);
         start       = 1'($urandom);
         class_ready = 1'($urandom);
         tick();
      end
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(class_valid), 32'd0);
      check("rst_data", {22'd0, class_idx, class_count, no_spike}, 32'd0);
      check("rst_sat", {26'd0, s_busy, s_valid, s_idx, s_count}, 32'd0);
      start       = 1'b0;
      class_ready = 1'b0;
      #2 reset = 1'b1;
      tick();

      run_decode("n0",   16'h5555, 0, 1'b0, 1'b0);
      run_decode("mix",  16'hAAFF, 0, 1'b0, 1'b1);
      run_decode("tie",  16'hFFFF, 0, 1'b0, 1'b0);
      run_decode("zero", 16'h0000, 0, 1'b0, 1'b0);
      run_decode("wait", 16'($urandom), 5, 1'b1, 1'b0);
      run_decode("rnd",  16'($urandom), 2, 1'b1, 1'b0);

      start = 1'b1;
      tick();
      start    = 1'b0;
      spike_in = 2'b01;
      repeat (3) tick();
      check("mid_busy", 32'(busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_busy", {30'd0, busy, s_busy}, 32'd0);
      check("mid_rst_out", {20'd0, class_valid, class_count, s_valid, s_count}, 32'd0);
      #2 reset = 1'b1;
      seen_valid = 0;
      repeat (15) begin
         tick();
         if (class_valid || s_valid || busy) seen_valid++;
      end
      check("mid_no_result", 32'(seen_valid), 32'd0);

      run_decode("again", 16'h5555, 1, 1'b0, 1'b0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
